// File: rtl/cv32e40p_clock_gate_ctrl.sv
// Clock-gate enable sequencer for one shared gated clock domain.
// Lives in the free-running clock domain next to the clock-gate cell.
// It grants requesters only while the gated clock is known stable.
// It keeps the enable asserted for a settle period before the first grant.
// It holds the enable for an idle hold-off after the last request goes away.
module cv32e40p_clock_gate_ctrl #(
    parameter int NUM_REQ     = 4,
    parameter int WAKE_CYCLES = 2,
    parameter int IDLE_CYCLES = 16,
    parameter int CNT_W       = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               force_on_i,
    input  logic               clr_cnt_i,
    output logic [NUM_REQ-1:0] ack_o,
    output logic               en_o,
    output logic               active_o,
    output logic [CNT_W-1:0]   wake_cnt_o
);

    // Counter widths never collapse to zero bits, even for 1-cycle delays.
    localparam int WAKE_W = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
    localparam int IDLE_W = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
    localparam logic [WAKE_W-1:0] WAKE_LOAD = WAKE_W'(WAKE_CYCLES - 1);
    localparam logic [IDLE_W-1:0] IDLE_LOAD = IDLE_W'((IDLE_CYCLES > 0) ? IDLE_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        ST_OFF       = 2'd0,
        ST_WAKING    = 2'd1,
        ST_ON        = 2'd2,
        ST_IDLE_WAIT = 2'd3
    } state_t;

    state_t              state_reg, state_next;
    logic [WAKE_W-1:0]   wake_cnt_reg, wake_cnt_next;
    logic [IDLE_W-1:0]   idle_cnt_reg, idle_cnt_next;
    logic [CNT_W-1:0]    wake_stat_reg, wake_stat_next;
    logic                en_reg;
    logic                any_req;
    logic                wake_event;
    logic                on_state;

    // force_on_i behaves like an extra requester that never gets a grant.
    assign any_req = (|req_i) | force_on_i;

    // State register, delay counters, registered enable and wake statistic.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg     <= ST_OFF;
            wake_cnt_reg  <= '0;
            idle_cnt_reg  <= '0;
            wake_stat_reg <= '0;
            en_reg        <= 1'b0;
        end else begin
            state_reg     <= state_next;
            wake_cnt_reg  <= wake_cnt_next;
            idle_cnt_reg  <= idle_cnt_next;
            wake_stat_reg <= wake_stat_next;
            // The enable follows the next state so it changes on the same edge as the state.
            en_reg        <= (state_next != ST_OFF);
        end
    end

    // Next-state logic: settle on wake-up, hold off on idle, and never emit short enable pulses.
    always_comb begin
        state_next    = state_reg;
        wake_cnt_next = wake_cnt_reg;
        idle_cnt_next = idle_cnt_reg;
        case (state_reg)
            ST_OFF: begin
                if (any_req) begin
                    state_next    = ST_WAKING;
                    wake_cnt_next = WAKE_LOAD;
                end
            end
            ST_WAKING: begin
                // Runs to completion even if every request disappears.
                if (wake_cnt_reg == '0) begin
                    state_next = ST_ON;
                end else begin
                    wake_cnt_next = wake_cnt_reg - WAKE_W'(1);
                end
            end
            ST_ON: begin
                if (!any_req) begin
                    if (IDLE_CYCLES == 0) begin
                        state_next = ST_OFF;
                    end else begin
                        state_next    = ST_IDLE_WAIT;
                        idle_cnt_next = IDLE_LOAD;
                    end
                end
            end
            ST_IDLE_WAIT: begin
                if (any_req) begin
                    state_next = ST_ON;
                end else if (idle_cnt_reg == '0) begin
                    state_next = ST_OFF;
                end else begin
                    idle_cnt_next = idle_cnt_reg - IDLE_W'(1);
                end
            end
            default: state_next = ST_OFF;
        endcase
    end

    // Wake statistic: count OFF->WAKING with saturation; clear wins over increment.
    always_comb begin
        wake_event     = (state_reg == ST_OFF) && any_req;
        wake_stat_next = wake_stat_reg;
        if (clr_cnt_i) begin
            wake_stat_next = '0;
        end else if (wake_event && (wake_stat_reg != {CNT_W{1'b1}})) begin
            wake_stat_next = wake_stat_reg + CNT_W'(1);
        end
    end

    // Output decode from the registered state only.
    always_comb begin
        on_state = (state_reg == ST_ON);
    end

    // Grants are shared: every requester that is asking is acked while ON.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ack
            assign ack_o[gi] = req_i[gi] & on_state;
        end
    endgenerate

    assign active_o   = on_state;
    assign en_o       = en_reg;
    assign wake_cnt_o = wake_stat_reg;

endmodule

// File: tb/tb_cv32e40p_clock_gate_ctrl.sv
// Bench for cv32e40p_clock_gate_ctrl.
// Instance A uses the default parameters.
// Instance B uses WAKE=1, IDLE=0, a 4-bit counter and a single requester.
// Instance B covers the direct ON->OFF path and counter saturation in a short run.
module tb_cv32e40p_clock_gate_ctrl;

    typedef struct {
        bit          b;      // 1: vector targets instance B
        logic [3:0]  req;
        logic        frc;
        logic        clr;
        int          rep;
        logic        en;
        logic [3:0]  ack;
        logic        act;
        logic [15:0] cnt;
        string       name;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic [3:0]  req_a = '0;
    logic        frc_a = 1'b0, clr_a = 1'b0;
    logic [3:0]  ack_a;
    logic        en_a, act_a;
    logic [15:0] cnt_a;

    logic [0:0]  req_b = '0;
    logic        frc_b = 1'b0, clr_b = 1'b0;
    logic [0:0]  ack_b;
    logic        en_b, act_b;
    logic [3:0]  cnt_b;

    int checks = 0;
    int errors = 0;
    vec_t tbl_a[$];
    vec_t tbl_b[$];
    vec_t exp_q[$];

    always #5 clk = ~clk;

    cv32e40p_clock_gate_ctrl #(.NUM_REQ(4), .WAKE_CYCLES(2), .IDLE_CYCLES(16), .CNT_W(16)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req_a), .force_on_i(frc_a), .clr_cnt_i(clr_a),
        .ack_o(ack_a), .en_o(en_a), .active_o(act_a), .wake_cnt_o(cnt_a)
    );

    cv32e40p_clock_gate_ctrl #(.NUM_REQ(1), .WAKE_CYCLES(1), .IDLE_CYCLES(0), .CNT_W(4)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req_b), .force_on_i(frc_b), .clr_cnt_i(clr_b),
        .ack_o(ack_b), .en_o(en_b), .active_o(act_b), .wake_cnt_o(cnt_b)
    );

    function automatic vec_t mk(bit b, logic [3:0] req, logic frc, logic clr, int rep,
                                logic en, logic [3:0] ack, logic act, logic [15:0] cnt, string name);
        vec_t v;
        v.b = b; v.req = req; v.frc = frc; v.clr = clr; v.rep = rep;
        v.en = en; v.ack = ack; v.act = act; v.cnt = cnt; v.name = name;
        return v;
    endfunction

    // Pop the oldest expectation and compare it with the selected instance.
    task automatic check_out();
        vec_t        e;
        logic        g_en, g_act;
        logic [3:0]  g_ack;
        logic [15:0] g_cnt;
        e = exp_q.pop_front();
        if (e.b) begin
            g_en = en_b; g_act = act_b; g_ack = {3'b000, ack_b}; g_cnt = {12'h000, cnt_b};
        end else begin
            g_en = en_a; g_act = act_a; g_ack = ack_a; g_cnt = cnt_a;
        end
        checks++;
        if ((g_en !== e.en) || (g_act !== e.act) || (g_ack !== e.ack) || (g_cnt !== e.cnt)) begin
            errors++;
            $display("FAIL %s: got en=%0b ack=%b active=%0b cnt=%h, expected en=%0b ack=%b active=%0b cnt=%h",
                     e.name, g_en, g_ack, g_act, g_cnt, e.en, e.ack, e.act, e.cnt);
        end else begin
            $display("ok   %s: en=%0b ack=%b active=%0b cnt=%h", e.name, g_en, g_ack, g_act, g_cnt);
        end
    endtask

    // Drive one vector for rep cycles just after the edge, and check at the falling edge.
    task automatic apply(input vec_t v);
        for (int r = 0; r < v.rep; r++) begin
            @(posedge clk);
            #1;
            if (v.b) begin
                req_b = v.req[0:0]; frc_b = v.frc; clr_b = v.clr;
                req_a = '0; frc_a = 1'b0; clr_a = 1'b0;
            end else begin
                req_a = v.req; frc_a = v.frc; clr_a = v.clr;
                req_b = '0; frc_b = 1'b0; clr_b = 1'b0;
            end
            exp_q.push_back(v);
            @(negedge clk);
            check_out();
        end
    endtask

    // Assert reset between edges; outputs must clear without a clock edge.
    task automatic reset_check(input string name);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ((en_a !== 1'b0) || (ack_a !== 4'b0000) || (act_a !== 1'b0) || (cnt_a !== 16'h0000)) begin
            errors++;
            $display("FAIL %s: got en=%0b ack=%b active=%0b cnt=%h, expected all zero",
                     name, en_a, ack_a, act_a, cnt_a);
        end else begin
            $display("ok   %s: outputs cleared asynchronously", name);
        end
        req_a = '0; frc_a = 1'b0; clr_a = 1'b0;
        req_b = '0; frc_b = 1'b0; clr_b = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [15:0] exp_cnt;

        // Basic wake / idle hold-off on A (cycle 0 = first cycle after reset release).
        tbl_a.push_back(mk(0, 4'b0001, 0, 0, 1,  0, 4'b0000, 0, 16'd0, "off_req0"));
        tbl_a.push_back(mk(0, 4'b0001, 0, 0, 2,  1, 4'b0000, 0, 16'd1, "waking"));
        tbl_a.push_back(mk(0, 4'b0001, 0, 0, 7,  1, 4'b0001, 1, 16'd1, "on_ack0"));
        tbl_a.push_back(mk(0, 4'b0000, 0, 0, 1,  1, 4'b0000, 1, 16'd1, "drop_on"));
        tbl_a.push_back(mk(0, 4'b0000, 0, 0, 16, 1, 4'b0000, 0, 16'd1, "idle_hold"));
        tbl_a.push_back(mk(0, 4'b0000, 0, 0, 2,  0, 4'b0000, 0, 16'd1, "off_again"));
        // Two requesters, then one drops; later re-request in IDLE_WAIT at idle_cnt=5.
        tbl_a.push_back(mk(0, 4'b0101, 0, 0, 1,  0, 4'b0000, 0, 16'd1, "off_req0101"));
        tbl_a.push_back(mk(0, 4'b0101, 0, 0, 2,  1, 4'b0000, 0, 16'd2, "waking2"));
        tbl_a.push_back(mk(0, 4'b0101, 0, 0, 3,  1, 4'b0101, 1, 16'd2, "ack_0101"));
        tbl_a.push_back(mk(0, 4'b0100, 0, 0, 3,  1, 4'b0100, 1, 16'd2, "ack_0100"));
        tbl_a.push_back(mk(0, 4'b0000, 0, 0, 1,  1, 4'b0000, 1, 16'd2, "drop_all"));
        tbl_a.push_back(mk(0, 4'b0000, 0, 0, 10, 1, 4'b0000, 0, 16'd2, "idle_15_to_6"));
        tbl_a.push_back(mk(0, 4'b0100, 0, 0, 1,  1, 4'b0000, 0, 16'd2, "rereq_idle5"));
        tbl_a.push_back(mk(0, 4'b0100, 0, 0, 2,  1, 4'b0100, 1, 16'd2, "back_on"));
        // force_on holds ON without acks; clr_cnt clears the statistic one edge later.
        tbl_a.push_back(mk(0, 4'b0000, 1, 0, 3,  1, 4'b0000, 1, 16'd2, "force_on"));
        tbl_a.push_back(mk(0, 4'b0000, 1, 1, 1,  1, 4'b0000, 1, 16'd2, "clr_issue"));
        tbl_a.push_back(mk(0, 4'b0000, 1, 0, 2,  1, 4'b0000, 1, 16'd0, "clr_done"));
        tbl_a.push_back(mk(0, 4'b0010, 1, 0, 1,  1, 4'b0010, 1, 16'd0, "force_req1"));
        tbl_a.push_back(mk(0, 4'b0000, 0, 0, 1,  1, 4'b0000, 1, 16'd0, "release"));
        tbl_a.push_back(mk(0, 4'b0000, 0, 0, 16, 1, 4'b0000, 0, 16'd0, "idle_hold2"));
        tbl_a.push_back(mk(0, 4'b0000, 0, 0, 1,  0, 4'b0000, 0, 16'd0, "off3"));
        // One-cycle request pulse: full WAKING, one ON cycle, then hold-off, never an ack.
        tbl_a.push_back(mk(0, 4'b1000, 0, 0, 1,  0, 4'b0000, 0, 16'd0, "pulse"));
        tbl_a.push_back(mk(0, 4'b0000, 0, 0, 2,  1, 4'b0000, 0, 16'd1, "pulse_waking"));
        tbl_a.push_back(mk(0, 4'b0000, 0, 0, 1,  1, 4'b0000, 1, 16'd1, "pulse_on"));
        tbl_a.push_back(mk(0, 4'b0000, 0, 0, 16, 1, 4'b0000, 0, 16'd1, "pulse_idle"));
        tbl_a.push_back(mk(0, 4'b0000, 0, 0, 1,  0, 4'b0000, 0, 16'd1, "pulse_off"));
        tbl_a.push_back(mk(0, 4'b0001, 0, 0, 1,  0, 4'b0000, 0, 16'd1, "off_req_again"));
        tbl_a.push_back(mk(0, 4'b0001, 0, 0, 1,  1, 4'b0000, 0, 16'd2, "mid_waking"));

        // After the mid-WAKING reset: clear beats a simultaneous increment.
        tbl_b.push_back(mk(0, 4'b0001, 0, 1, 1,  0, 4'b0000, 0, 16'd0, "clr_and_wake"));
        tbl_b.push_back(mk(0, 4'b0001, 0, 0, 2,  1, 4'b0000, 0, 16'd0, "clr_priority"));
        tbl_b.push_back(mk(0, 4'b0001, 0, 0, 1,  1, 4'b0001, 1, 16'd0, "on_before_rst"));

        // Reset state: held through edges with every input asking for the clock.
        req_a = 4'hF; frc_a = 1'b1; req_b = 1'b1; frc_b = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ((en_a !== 1'b0) || (ack_a !== 4'b0000) || (act_a !== 1'b0) || (cnt_a !== 16'h0000) ||
            (en_b !== 1'b0) || (ack_b !== 1'b0) || (act_b !== 1'b0) || (cnt_b !== 4'h0)) begin
            errors++;
            $display("FAIL reset_state: got A en=%0b ack=%b act=%0b cnt=%h B en=%0b ack=%b act=%0b cnt=%h, expected all zero",
                     en_a, ack_a, act_a, cnt_a, en_b, ack_b, act_b, cnt_b);
        end else begin
            $display("ok   reset_state: all outputs zero");
        end
        req_a = '0; frc_a = 1'b0; req_b = '0; frc_b = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;

        foreach (tbl_a[i]) apply(tbl_a[i]);
        reset_check("rst_mid_waking");
        foreach (tbl_b[i]) apply(tbl_b[i]);
        reset_check("rst_while_on");

        // Instance B: WAKE=1, IDLE=0 -> one settle cycle, direct ON->OFF.
        apply(mk(1, 4'b0001, 0, 0, 1, 0, 4'b0000, 0, 16'd0, "b_off_req"));
        apply(mk(1, 4'b0001, 0, 0, 1, 1, 4'b0000, 0, 16'd1, "b_waking"));
        apply(mk(1, 4'b0001, 0, 0, 1, 1, 4'b0001, 1, 16'd1, "b_on_ack"));
        apply(mk(1, 4'b0000, 0, 0, 1, 1, 4'b0000, 1, 16'd1, "b_drop"));
        apply(mk(1, 4'b0000, 0, 0, 1, 0, 4'b0000, 0, 16'd1, "b_off_direct"));
        // Pulse wakes until the 4-bit counter saturates, plus one extra wake.
        for (int n = 2; n <= 17; n++) begin
            exp_cnt = (n - 1 > 15) ? 16'd15 : 16'(n - 1);
            apply(mk(1, 4'b0001, 0, 0, 1, 0, 4'b0000, 0, exp_cnt, "b_pulse_off"));
            exp_cnt = (n > 15) ? 16'd15 : 16'(n);
            apply(mk(1, 4'b0000, 0, 0, 1, 1, 4'b0000, 0, exp_cnt, "b_pulse_wake"));
            apply(mk(1, 4'b0000, 0, 0, 1, 1, 4'b0000, 1, exp_cnt, "b_pulse_on"));
        end
        apply(mk(1, 4'b0000, 0, 1, 1, 0, 4'b0000, 0, 16'd15, "b_saturated"));
        apply(mk(1, 4'b0000, 0, 0, 1, 0, 4'b0000, 0, 16'd0,  "b_cleared"));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
